mac_tx_frame_fifo: RTL
======================

# mac_tx_frame_fifo

Store-and-forward transmit frame FIFO that sits directly upstream of the MAC TX encapsulation stage. It accepts a byte-wide AXI-Stream from the user/host side and releases a frame downstream only once that frame has been received in full and is error-free. Frames marked bad, or frames that overflow the buffer, are discarded completely, so the encapsulator never starts a frame it cannot finish.

## Interface
- DEPTH, 2048: buffer size in bytes; power of two, ≥ 64.
- PTR_W, $clog2(DEPTH)+1: pointer width, including the wrap bit; derived, not overridden.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_tdata  in  8  ingress byte.
- s_tvalid  in  1  ingress beat valid.
- s_tready  out  1  ingress ready; 1 whenever not in reset (drop semantics, never back-pressures).
- s_tlast  in  1  last byte of frame.
- s_tuser  in  1  frame-bad flag; sampled only on the tlast beat.
- m_tdata  out  8  egress byte.
- m_tvalid  out  1  egress beat valid.
- m_tready  in  1  egress ready.
- m_tlast  out  1  egress last byte.
- m_tuser  out  1  tied 0 (bad frames never leave).
- frame_cnt  out  PTR_W  number of complete frames stored and not yet fully read out.
- drop_bad  out  1  one-cycle pulse: frame dropped because s_tuser=1 on tlast.
- drop_ovf  out  1  one-cycle pulse: frame dropped because of overflow (pulses on that frame's tlast).

## Operation
- Storage: DEPTH × 9-bit RAM holding {tlast, tdata}; synchronous write and synchronous read.
- Pointers, all PTR_W bits wide, with modulo-2^PTR_W arithmetic:
  - wr_cur: speculative write pointer.
  - wr_com: committed write pointer.
  - rd: read pointer.
- Write acceptance: a beat is accepted when s_tvalid && s_tready.
  - Space check: (wr_cur − rd) < DEPTH. If it passes and the frame is not in the dropping state, write RAM[wr_cur] and increment wr_cur.
  - If an accepted beat finds no space, set `dropping`. Every further beat of that frame is discarded until its tlast.
- Frame end (tlast accepted):
  - Good (not dropping, space available, s_tuser=0): the tlast byte is written, wr_com <= wr_cur+1, wr_cur <= wr_cur+1, frame_cnt increments.
  - Bad (s_tuser=1, not dropping): wr_cur <= wr_com, drop_bad pulses.
  - Overflow (dropping, or the tlast beat itself lacks space): wr_cur <= wr_com, `dropping` clears, drop_ovf pulses. s_tuser is ignored; drop_bad does not pulse.
- Read side: a single output register.
  - Load condition: (rd != wr_com) && (!m_tvalid || m_tready). On load: {m_tlast, m_tdata} <= RAM[rd], m_tvalid <= 1, rd increments.
  - Otherwise, if m_tready && m_tvalid, m_tvalid <= 0.
- Reads never enter the uncommitted region.
- frame_cnt decrements on an egress handshake with m_tlast=1. Increment and decrement in the same cycle leave it unchanged.

## Timing
- Reset values: s_tready=0 during reset and 1 from the first cycle after; m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, frame_cnt=0, drop_bad=0, drop_ovf=0. All pointers are 0 and `dropping` is 0.
- Reset mid-frame: the partial ingress frame and all stored frames are lost, and egress stops immediately.
- Latency: good tlast accepted at edge E → wr_com updated at E → first byte loaded at E+1 → m_tvalid=1 in the cycle after E+1.
- Throughput: 1 byte/clk on egress while m_tready=1 and committed data remain. Back-to-back frames leave no bubble between them.
- The write of frame N+1 proceeds concurrently with the read of frame N.
- Simultaneous tlast commit and a read of the final committed byte: the newly committed data is visible to the load condition on the next edge.
- Maximum storable frame is DEPTH bytes. A frame longer than DEPTH is always dropped via drop_ovf.
- Pointer wrap: occupancy is computed from full-width pointer differences and is correct across the 2^PTR_W rollover.
- drop_* pulses assert in the cycle after the tlast edge and last exactly one cycle.

## Test plan
- DEPTH=64. A 60-byte frame 0x00..0x3B with m_tready=1 → egress bytes 0x00..0x3B in order, m_tlast only on 0x3B, m_tvalid rising 2 cycles after the tlast edge, frame_cnt 0→1→0.
- Three 20-byte frames back-to-back with m_tready=0 → frame_cnt=3. Then m_tready=1 → 60 consecutive valid beats with no gaps, and m_tlast on beats 20, 40 and 60.
- A 30-byte frame with s_tuser=1 on tlast, followed by a good 10-byte frame → drop_bad pulses once, only the 10-byte frame egresses, frame_cnt peaks at 1.
- A 70-byte frame with m_tready=0 → drop_ovf pulses once on beat 70, nothing egresses, frame_cnt=0. A following 64-byte frame is stored and egresses intact.
- m_tready toggling 1/0 every cycle during a 50-byte frame → every byte delivered exactly once and m_tdata stable while m_tvalid && !m_tready. Repeat for 200 frames to force pointer wrap → data intact.
- Reset asserted mid-way through ingress of byte 15 of a frame and mid-way through egress of a previously stored frame → next cycle: m_tvalid=0, frame_cnt=0. A new 46-byte frame afterwards egresses correctly.

Source files
------------

// File: rtl/mac_tx_frame_fifo_if.sv
// Byte-wide AXI-Stream link with tuser frame-bad flag.
interface mac_tx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/mac_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: a frame is released downstream only after
// its last byte has arrived intact; bad or oversized frames are discarded.
module mac_tx_frame_fifo #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                      clk,
    input  logic                      reset,
    mac_tx_frame_fifo_if.slave        s_axis,
    mac_tx_frame_fifo_if.master       m_axis,
    output logic [$clog2(DEPTH):0]    frame_cnt,
    output logic                      drop_bad,
    output logic                      drop_ovf
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [8:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_cur_q, wr_cur_d;
    logic [PTR_W-1:0] wr_com_q, wr_com_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] occ;
    logic             dropping_q, dropping_d;
    logic             ready_q;
    logic             mvalid_q, mvalid_d;
    logic             mlast_q;
    logic [7:0]       mdata_q;
    logic             dbad_d, dovf_d, dbad_q, dovf_q;
    logic             accept, space, mem_we, load, commit, pop_last;

    assign occ   = wr_cur_q - rd_q;
    assign space = occ < PTR_W'(DEPTH);

    // Next-state: speculative write, commit/rollback on tlast, single-register egress.
    always_comb begin
        wr_cur_d   = wr_cur_q;
        wr_com_d   = wr_com_q;
        rd_d       = rd_q;
        dropping_d = dropping_q;
        mvalid_d   = mvalid_q;
        dbad_d     = 1'b0;
        dovf_d     = 1'b0;
        mem_we     = 1'b0;
        commit     = 1'b0;
        accept     = s_axis.tvalid && ready_q;

        if (accept) begin
            if (s_axis.tlast) begin
                if (dropping_q || !space) begin
                    wr_cur_d   = wr_com_q;
                    dropping_d = 1'b0;
                    dovf_d     = 1'b1;
                end else if (s_axis.tuser) begin
                    wr_cur_d = wr_com_q;
                    dbad_d   = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_cur_d = wr_cur_q + PTR_W'(1);
                    wr_com_d = wr_cur_q + PTR_W'(1);
                    commit   = 1'b1;
                end
            end else if (!dropping_q) begin
                if (!space) begin
                    dropping_d = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_cur_d = wr_cur_q + PTR_W'(1);
                end
            end
        end

        // Only committed bytes are ever loaded into the output register.
        load = (rd_q != wr_com_q) && (!mvalid_q || m_axis.tready);
        if (load) begin
            mvalid_d = 1'b1;
            rd_d     = rd_q + PTR_W'(1);
        end else if (m_axis.tready && mvalid_q) begin
            mvalid_d = 1'b0;
        end

        pop_last = mvalid_q && m_axis.tready && mlast_q;
        cnt_d    = cnt_q;
        if (commit && !pop_last) begin
            cnt_d = cnt_q + PTR_W'(1);
        end else if (!commit && pop_last) begin
            cnt_d = cnt_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cur_q   <= '0;
            wr_com_q   <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            dropping_q <= 1'b0;
            ready_q    <= 1'b0;
            mvalid_q   <= 1'b0;
            mlast_q    <= 1'b0;
            mdata_q    <= '0;
            dbad_q     <= 1'b0;
            dovf_q     <= 1'b0;
        end else begin
            wr_cur_q   <= wr_cur_d;
            wr_com_q   <= wr_com_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            dropping_q <= dropping_d;
            ready_q    <= 1'b1;
            mvalid_q   <= mvalid_d;
            dbad_q     <= dbad_d;
            dovf_q     <= dovf_d;
            if (load) begin
                {mlast_q, mdata_q} <= mem[rd_q[AW-1:0]];
            end
        end
    end

    // Frame storage array, write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_cur_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = mvalid_q;
    assign m_axis.tdata  = mdata_q;
    assign m_axis.tlast  = mlast_q;
    assign m_axis.tuser  = 1'b0;
    assign frame_cnt     = cnt_q;
    assign drop_bad      = dbad_q;
    assign drop_ovf      = dovf_q;
endmodule
